// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM-subset multicycle control unit.
// Holds the FSM state encoding and the field encodings driven onto the
// datapath: ALU operations, instruction condition codes, opcode classes,
// the data-processing command field, and the ResultSrc / ALUSrcB selects.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Op field (Instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Data-processing command (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_RSTVEC = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Condition codes (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluation.
// Ports:
//   Cond   in  4  instruction condition field
//   Flags  in  4  current {N,Z,C,V}
//   CondEx out 1  instruction is allowed to execute
// The reserved code 4'b1111 never executes.
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = Flags;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = !z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = !c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = !n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = !v;
            COND_HI: CondEx = c && !z;
            COND_LS: CondEx = !c || z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = !z && (n == v);
            COND_LE: CondEx = z || (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control unit for the ARM-subset shared-memory datapath.
// Sequences FETCH/DECODE/execute states, owns the NZCV flags register and
// stalls on mem_ready for instruction fetch and data accesses.
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   Instr[31:0]             instruction register contents
//   ALUFlags[3:0]           {N,Z,C,V} produced by the ALU this cycle
//   mem_ready               memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUControl[1:0]
//   ImmSrc[1:0], RegSrc[1:0]  combinational decode of Instr
//   Flags[3:0]              current NZCV register
//   illegal_op              one-cycle pulse in DECODE for Op==2'b11
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter bit RESET_PC_WRITE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags,
    output logic        illegal_op
);

    state_t     state_q, state_d;
    logic [3:0] flags_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       cond_ex;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_is_pc = (Instr[15:12] == 4'hF);

    logic unused_instr;
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign ImmSrc = op;
    assign RegSrc = {(op == OP_MEM) && !funct[0], (op == OP_BR)};
    assign Flags  = flags_q;

    arm_cond_check u_cond (
        .Cond   (cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // Data-processing decode: ALU op, whether C/V are architecturally
    // written, and whether the result skips writeback (CMP or unknown cmd).
    logic [1:0] dp_alu;
    logic       dp_arith;
    logic       dp_nowb;

    always_comb begin
        dp_alu   = ALU_ADD;
        dp_arith = 1'b0;
        dp_nowb  = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            CMD_SUB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_CMP: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_nowb = 1'b1; end
            default: begin dp_alu = ALU_ADD; dp_nowb = 1'b1; end
        endcase
    end

    // Flags are only written at the edge leaving an execute state, which
    // can never coincide with a DECODE condition check.
    logic flags_we;
    assign flags_we = ((state_q == S_EXECR) || (state_q == S_EXECI)) && funct[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else if (flags_we) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (dp_arith)
                flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!cond_ex) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state_d = dp_nowb ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    // Output decode
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_RST: begin
                // Qualified by reset_n so nothing is strobed while held in reset.
                if (RESET_PC_WRITE && reset_n) begin
                    PCWrite   = 1'b1;
                    ResultSrc = RES_RSTVEC;
                end
            end
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                // PC+8 computed here is what reads of R15 observe.
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                illegal_op = cond_ex && (op == OP_ILL);
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = !rd_is_pc;
                PCWrite   = rd_is_pc;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = dp_alu;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = !rd_is_pc;
                PCWrite   = rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
